// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: initialises a small register file after reset, then
// shares its single write port and single read port between requesters A
// and B. Requests are served one at a time, alternating when both contend.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_INIT   | writing entry i = i, one entry per cycle; requests wait
// S_IDLE   | arbitrating; latches the winner's we/addr/wdata
// S_ACCESS | winner's gnt; rf write or rf read (read data registered)
// S_RESP   | winner's done/err/rdata; round-robin pointer updated
module regfile_access_ctrl #(
    parameter int DW    = 2,
    parameter int DEPTH = 3,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_done,
    output logic          a_err,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_done,
    output logic          b_err,
    output logic [DW-1:0] b_rdata,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic [AW-1:0] rf_raddr,
    input  logic [DW-1:0] rf_rdata,
    output logic          init_busy
);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_ACCESS, S_RESP} state_t;

    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state_q;
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] a_rdata_q;
    logic [DW-1:0] b_rdata_q;
    logic          we_q;
    logic          sel_b_q;
    logic          err_q;
    logic          last_b_q;

    logic addr_ok;
    logic pick_b;

    // Address range check on the latched address; B wins only if A is idle or A won last.
    assign addr_ok = ({1'b0, addr_q} < DEPTH_W);
    assign pick_b  = b_req & (~a_req | ~last_b_q);

    // Sequencer: init counter, arbitration latch, read-data capture, round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_INIT;
            cnt_q     <= '0;
            last_b_q  <= 1'b1;
            sel_b_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            case (state_q)
                S_INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR) state_q <= S_IDLE;
                end
                S_IDLE: begin
                    if (a_req || b_req) begin
                        sel_b_q <= pick_b;
                        we_q    <= pick_b ? b_we    : a_we;
                        addr_q  <= pick_b ? b_addr  : a_addr;
                        wdata_q <= pick_b ? b_wdata : a_wdata;
                        state_q <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    err_q <= ~addr_ok;
                    if (!we_q) begin
                        if (sel_b_q) b_rdata_q <= addr_ok ? rf_rdata : '0;
                        else         a_rdata_q <= addr_ok ? rf_rdata : '0;
                    end
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    last_b_q <= sel_b_q;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    // State-decoded outputs; a held reset silences everything but init_busy,
    // so a transaction interrupted by reset never shows gnt, done or a write.
    always_comb begin
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        rf_raddr  = '0;
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        a_done    = 1'b0;
        b_done    = 1'b0;
        a_err     = 1'b0;
        b_err     = 1'b0;
        init_busy = reset || (state_q == S_INIT);
        a_rdata   = reset ? '0 : a_rdata_q;
        b_rdata   = reset ? '0 : b_rdata_q;
        if (!reset) begin
            case (state_q)
                S_INIT: begin
                    rf_we    = 1'b1;
                    rf_waddr = cnt_q;
                    rf_wdata = DW'(cnt_q);
                end
                S_ACCESS: begin
                    a_gnt = ~sel_b_q;
                    b_gnt = sel_b_q;
                    if (we_q) begin
                        if (addr_ok) begin
                            rf_we    = 1'b1;
                            rf_waddr = addr_q;
                            rf_wdata = wdata_q;
                        end
                    end else begin
                        rf_raddr = addr_q;
                    end
                end
                S_RESP: begin
                    a_done = ~sel_b_q;
                    b_done = sel_b_q;
                    a_err  = ~sel_b_q & err_q;
                    b_err  = sel_b_q & err_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: a plain array acts as the register file
// storage; a reference model (contents, per-requester read data, last
// winner) predicts every grant, write pulse and response.
module tb_regfile_access_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_req, a_we, b_req, b_we;
    logic [1:0] a_addr, a_wdata, b_addr, b_wdata;
    logic       a_gnt, a_done, a_err, b_gnt, b_done, b_err;
    logic [1:0] a_rdata, b_rdata;
    logic       rf_we;
    logic [1:0] rf_waddr, rf_wdata, rf_raddr, rf_rdata;
    logic       init_busy;

    int checks   = 0;
    int failures = 0;

    // reference model
    logic [1:0] ref_mem [0:3];
    logic [1:0] ref_rd  [0:1];
    logic       last_b;

    // register file storage
    logic [1:0] rf_mem [0:3];

    always #5 clk = ~clk;

    always @(posedge clk) if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
    assign rf_rdata = rf_mem[rf_raddr];

    regfile_access_ctrl #(.DW(2), .DEPTH(3), .AW(2)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_done(a_done), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_done(b_done), .b_err(b_err), .b_rdata(b_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .init_busy(init_busy)
    );

    task automatic model_reset();
        for (int i = 0; i < 4; i++) ref_mem[i] = 2'(i);
        ref_rd[0] = 2'd0;
        ref_rd[1] = 2'd0;
        last_b    = 1'b1;
    endtask

    // Reset and run through init, ending on the first IDLE negedge.
    task automatic do_reset();
        reset = 1'b1;
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(negedge clk);
        model_reset();
    endtask

    // Raise the requested reqs at an IDLE negedge and serve every pending
    // request, checking grant choice/latency, rf port activity and response.
    task automatic serve(input logic ra, input logic rb);
        logic       pa, pb, wb, w_we, valid;
        logic [1:0] w_addr, w_wd;
        int         w;
        pa = ra; pb = rb;
        a_req = ra; b_req = rb;
        while (pa || pb) begin
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!(a_gnt || b_gnt) && w < 8);
            if (!(a_gnt || b_gnt)) begin
                checks++; failures++;
                $display("FAIL gnt_timeout: no gnt after %0d cycles, want a gnt after 1", w);
                a_req = 1'b0; b_req = 1'b0;
                return;
            end
            wb     = (pa && pb) ? ~last_b : pb;
            w_we   = wb ? b_we    : a_we;
            w_addr = wb ? b_addr  : a_addr;
            w_wd   = wb ? b_wdata : a_wdata;
            valid  = (int'(w_addr) < 3);
            checks++;
            if ({a_gnt, b_gnt} !== {~wb, wb} || w != 1) begin
                failures++;
                $display("FAIL gnt_order: got a_gnt=%0b b_gnt=%0b after %0d cycles, want a_gnt=%0b b_gnt=%0b after 1",
                         a_gnt, b_gnt, w, ~wb, wb);
            end
            checks++;
            if (rf_we !== (w_we && valid)) begin
                failures++;
                $display("FAIL access_we: got rf_we=%0b, want %0b (we=%0b addr=%0d)", rf_we, w_we && valid, w_we, w_addr);
            end
            if (w_we && valid) begin
                checks++;
                if (rf_waddr !== w_addr || rf_wdata !== w_wd) begin
                    failures++;
                    $display("FAIL access_wr: got waddr=%0d wdata=%0d, want %0d %0d", rf_waddr, rf_wdata, w_addr, w_wd);
                end
            end
            if (!w_we) begin
                checks++;
                if (rf_raddr !== w_addr) begin
                    failures++;
                    $display("FAIL access_raddr: got %0d, want %0d", rf_raddr, w_addr);
                end
            end
            if (wb) begin b_req = 1'b0; pb = 1'b0; end
            else    begin a_req = 1'b0; pa = 1'b0; end
            @(negedge clk);
            if (w_we && valid) ref_mem[w_addr] = w_wd;
            if (!w_we) ref_rd[wb] = valid ? ref_mem[w_addr] : 2'd0;
            checks++;
            if ({a_done, b_done} !== {~wb, wb} ||
                {a_err, b_err} !== {~wb & ~valid, wb & ~valid} ||
                a_rdata !== ref_rd[0] || b_rdata !== ref_rd[1]) begin
                failures++;
                $display("FAIL resp: got done=%0b%0b err=%0b%0b rdata=%0d/%0d, want done=%0b%0b err=%0b%0b rdata=%0d/%0d",
                         a_done, b_done, a_err, b_err, a_rdata, b_rdata,
                         ~wb, wb, ~wb & ~valid, wb & ~valid, ref_rd[0], ref_rd[1]);
            end
            last_b = wb;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_req = 1'b0; b_req = 1'b0;
        a_we = 1'b0; b_we = 1'b0;
        a_addr = 2'd0; b_addr = 2'd0; a_wdata = 2'd0; b_wdata = 2'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (init_busy !== 1'b1 || rf_we !== 1'b0 || {a_gnt, b_gnt, a_done, b_done, a_err, b_err} !== 6'b0 ||
            a_rdata !== 2'd0 || b_rdata !== 2'd0) begin
            failures++;
            $display("FAIL reset_outputs: got init_busy=%0b rf_we=%0b gnt=%0b%0b done=%0b%0b, want 1 0 00 00",
                     init_busy, rf_we, a_gnt, b_gnt, a_done, b_done);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (init_busy !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 2'(i) || rf_wdata !== 2'(i)) begin
                failures++;
                $display("FAIL init_write%0d: got busy=%0b we=%0b waddr=%0d wdata=%0d, want 1 1 %0d %0d",
                         i, init_busy, rf_we, rf_waddr, rf_wdata, i, i);
            end
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (init_busy !== 1'b0 || rf_we !== 1'b0 || rf_waddr !== 2'd0 || rf_wdata !== 2'd0 || rf_raddr !== 2'd0) begin
                failures++;
                $display("FAIL post_init: got busy=%0b we=%0b waddr=%0d wdata=%0d raddr=%0d, want all 0",
                         init_busy, rf_we, rf_waddr, rf_wdata, rf_raddr);
            end
        end
        model_reset();
    endtask

    task automatic test_read_a();
        a_we = 1'b0; a_addr = 2'd2;
        serve(1'b1, 1'b0);
    endtask

    task automatic test_write_b_read_a();
        b_we = 1'b1; b_addr = 2'd1; b_wdata = 2'd3;
        serve(1'b0, 1'b1);
        a_we = 1'b0; a_addr = 2'd1;
        serve(1'b1, 1'b0);
    endtask

    task automatic test_invalid_write();
        a_we = 1'b1; a_addr = 2'd3; a_wdata = 2'($urandom_range(0, 3));
        serve(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            a_we = 1'b0; a_addr = 2'(i);
            serve(1'b1, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            a_we = 1'($urandom_range(0, 1)); a_addr = 2'($urandom_range(0, 2)); a_wdata = 2'($urandom_range(0, 3));
            b_we = 1'($urandom_range(0, 1)); b_addr = 2'($urandom_range(0, 2)); b_wdata = 2'($urandom_range(0, 3));
            serve(1'b1, 1'b1);
        end
    endtask

    task automatic test_random();
        logic [1:0] r;
        for (int k = 0; k < 30; k++) begin
            r = 2'($urandom_range(1, 3));
            a_we = 1'($urandom_range(0, 1)); a_addr = 2'($urandom_range(0, 3)); a_wdata = 2'($urandom_range(0, 3));
            b_we = 1'($urandom_range(0, 1)); b_addr = 2'($urandom_range(0, 3)); b_wdata = 2'($urandom_range(0, 3));
            serve(r[0], r[1]);
        end
    endtask

    task automatic test_reset_mid();
        b_we = 1'b1; b_addr = 2'd0; b_wdata = 2'd3;
        a_we = 1'b0; a_addr = 2'($urandom_range(0, 2));
        b_req = 1'b1;
        @(negedge clk);
        checks++;
        if (b_gnt !== 1'b1) begin
            failures++;
            $display("FAIL mid_gnt: got b_gnt=%0b, want 1", b_gnt);
        end
        reset = 1'b1; a_req = 1'b1; b_req = 1'b0;
        #1;
        checks++;
        if (b_gnt !== 1'b0 || rf_we !== 1'b0 || init_busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_out: got b_gnt=%0b rf_we=%0b busy=%0b, want 0 0 1", b_gnt, rf_we, init_busy);
        end
        @(negedge clk);
        checks++;
        if (b_done !== 1'b0 || init_busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_abandon: got b_done=%0b busy=%0b, want 0 1", b_done, init_busy);
        end
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (b_done !== 1'b0 || init_busy !== 1'b1 || a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
                failures++;
                $display("FAIL mid_init: got b_done=%0b busy=%0b gnt=%0b%0b, want 0 1 00", b_done, init_busy, a_gnt, b_gnt);
            end
        end
        @(negedge clk);
        model_reset();
        checks++;
        if (init_busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_idle: got busy=%0b, want 0", init_busy);
        end
        serve(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            b_we = 1'b0; b_addr = 2'(i);
            serve(1'b0, 1'b1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_a();
        test_write_b_read_a();
        test_invalid_write();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
